// File: rtl/mem_access.sv
// Memory stage of the RV32I pipeline: issues data-memory requests, aligns and
// extends load data, flags misaligned/faulting accesses and registers results for writeback.
module mem_access #(
  parameter int XLEN    = 32,
  parameter int EX_W    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pipeline_valid_in,
  input  logic [4:0]      opcode_in,
  input  logic [2:0]      funct3_in,
  input  logic            nop_in,
  input  logic [XLEN-1:0] alu_result_in,
  input  logic [XLEN-1:0] store_data_in,
  input  logic [4:0]      rd_addr_in,
  input  logic            exception_valid_in,
  input  logic [EX_W-1:0] exception_in,
  input  logic            halt_in,
  output logic            stall_out,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_err,
  output logic            pipeline_valid_out,
  output logic [4:0]      opcode_out,
  output logic            nop_out,
  output logic [4:0]      rd_addr_out,
  output logic            halt_out,
  output logic [XLEN-1:0] result_out,
  output logic            exception_valid_out,
  output logic [EX_W-1:0] exception_out
);
  // Handshake: dmem_req rises with the registered request and stays, with all
  // dmem_* fields stable, until the first cycle dmem_ack is high (which may be
  // the very first cycle of the request); the transfer completes on that cycle.
  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_STORE = 5'b01000;

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;

  logic [7:0]      cnt_q;
  logic [2:0]      pend_f3;
  logic [1:0]      pend_off;
  logic            pend_load;
  logic            pend_halt;

  logic            is_load, is_store, mem_op, size_ok, misaligned, issue;
  logic            pass_exc_valid;
  logic [EX_W-1:0] pass_exc;
  logic [3:0]      be_d;
  logic [XLEN-1:0] wdata_d;
  logic            timeout_hit, done, fault;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [XLEN-1:0] load_data;

  always_comb begin
    is_load    = (opcode_in == OP_LOAD);
    is_store   = (opcode_in == OP_STORE);
    mem_op     = pipeline_valid_in && (is_load || is_store) && !nop_in && !exception_valid_in;
    size_ok    = is_load ? (funct3_in inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                         : (funct3_in inside {3'b000, 3'b001, 3'b010});
    misaligned = ((funct3_in[1:0] == 2'b01) && alu_result_in[0]) ||
                 ((funct3_in[1:0] == 2'b10) && (alu_result_in[1:0] != 2'b00));
    issue      = mem_op && size_ok && !misaligned;

    pass_exc_valid = 1'b0;
    pass_exc       = '0;
    if (exception_valid_in) begin
      pass_exc_valid = 1'b1;
      pass_exc       = exception_in;
    end else if (mem_op && !size_ok) begin
      pass_exc_valid = 1'b1;
      pass_exc       = EX_W'(2);
    end else if (mem_op && misaligned) begin
      pass_exc_valid = 1'b1;
      pass_exc       = is_load ? EX_W'(4) : EX_W'(6);
    end

    case (funct3_in[1:0])
      2'b00: begin
        be_d    = 4'b0001 << alu_result_in[1:0];
        wdata_d = {4{store_data_in[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << {alu_result_in[1], 1'b0};
        wdata_d = {2{store_data_in[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = store_data_in;
      end
    endcase
  end

  // Load lane selection uses the byte offset captured at issue time.
  always_comb begin
    byte_v = dmem_rdata[{pend_off, 3'b000} +: 8];
    half_v = dmem_rdata[{pend_off[1], 4'b0000} +: 16];
    case (pend_f3)
      3'b000:  load_data = {{(XLEN-8){byte_v[7]}}, byte_v};
      3'b100:  load_data = {{(XLEN-8){1'b0}}, byte_v};
      3'b001:  load_data = {{(XLEN-16){half_v[15]}}, half_v};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, half_v};
      default: load_data = dmem_rdata;
    endcase
  end

  always_comb begin
    timeout_hit = !dmem_ack && (cnt_q == 8'(TIMEOUT - 1));
    done        = dmem_ack || timeout_hit;
    fault       = dmem_ack ? dmem_err : 1'b1;
    stall_out   = (state_q == BUSY);
    state_d     = state_q;
    case (state_q)
      IDLE: if (issue) state_d = BUSY;
      BUSY: if (done)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q               <= '0;
      pend_f3             <= '0;
      pend_off            <= '0;
      pend_load           <= 1'b0;
      pend_halt           <= 1'b0;
      dmem_req            <= 1'b0;
      dmem_we             <= 1'b0;
      dmem_addr           <= '0;
      dmem_be             <= '0;
      dmem_wdata          <= '0;
      pipeline_valid_out  <= 1'b0;
      opcode_out          <= '0;
      nop_out             <= 1'b0;
      rd_addr_out         <= '0;
      halt_out            <= 1'b0;
      result_out          <= '0;
      exception_valid_out <= 1'b0;
      exception_out       <= '0;
    end else begin
      pipeline_valid_out <= 1'b0;
      if (state_q == IDLE) begin
        if (pipeline_valid_in) begin
          opcode_out  <= opcode_in;
          nop_out     <= nop_in;
          rd_addr_out <= rd_addr_in;
          pend_f3     <= funct3_in;
          pend_off    <= alu_result_in[1:0];
          pend_load   <= is_load;
          pend_halt   <= halt_in;
          if (issue) begin
            dmem_req   <= 1'b1;
            dmem_we    <= is_store;
            dmem_addr  <= {alu_result_in[XLEN-1:2], 2'b00};
            dmem_be    <= be_d;
            dmem_wdata <= wdata_d;
            cnt_q      <= '0;
          end else begin
            pipeline_valid_out  <= 1'b1;
            result_out          <= alu_result_in;
            exception_valid_out <= pass_exc_valid;
            exception_out       <= pass_exc;
            halt_out            <= halt_out | halt_in;
          end
        end
      end else if (done) begin
        dmem_req            <= 1'b0;
        pipeline_valid_out  <= 1'b1;
        halt_out            <= halt_out | pend_halt;
        exception_valid_out <= fault;
        if (fault) begin
          exception_out <= pend_load ? EX_W'(5) : EX_W'(7);
          result_out    <= '0;
        end else begin
          exception_out <= '0;
          result_out    <= pend_load ? load_data : '0;
        end
      end else begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end
endmodule
